err_frame_tx: RTL and testbench

//  Transmit side of the CAN error-frame logic. On request, drives an error flag
//  (6 dominant, or 6 recessive if error-passive) onto txOut, tolerates flag

---
 rtl/err_frame_pkg.sv | 19 +
 rtl/sample_qualifier.sv | 27 ++
 rtl/err_frame_tx.sv | 104 ++++++++++
 tb/tb_err_frame_tx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/err_frame_pkg.sv
// err_frame_pkg: shared state encodings and default sizing for the CAN error-frame logic
package err_frame_pkg;
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        FLAG     = 4'b0010,
        WAIT_REC = 4'b0100,
        DELIM    = 4'b1000
    } state_t;

    typedef enum logic [1:0] {s_init, s_sample1, s_sample2, s_sample3} sample_state_t;

    localparam int FLAG_BITS_DEF  = 6;
    localparam int DELIM_BITS_DEF = 8;
    localparam int STUCK_BITS_DEF = 8;

    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/sample_qualifier.sv
// sample_qualifier: one sampleValid strobe per bit from 1 or 3 samplePulses
module sample_qualifier
    import err_frame_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic samplePulse,
    input  logic rateSelector,
    output logic sampleValid
);
    sample_state_t state;

    // s_sample3 lasts exactly one cycle, so the strobe comes straight off the state register
    assign sampleValid = state == s_sample3;

    always_ff @(posedge clk) begin
        if (!resetN)
            state <= s_init;
        else
            case (state)
                s_init:    if (samplePulse) state <= rateSelector ? s_sample1 : s_sample3;
                s_sample1: if (samplePulse) state <= s_sample2;
                s_sample2: if (samplePulse) state <= s_sample3;
                default:   state <= s_init;
            endcase
    end
endmodule

// File: rtl/err_frame_tx.sv
// err_frame_tx: transmits a CAN error flag, then watches the bus for the recessive delimiter
module err_frame_tx
    import err_frame_pkg::*;
#(
    parameter int FLAG_BITS  = FLAG_BITS_DEF,
    parameter int DELIM_BITS = DELIM_BITS_DEF,
    parameter int STUCK_BITS = STUCK_BITS_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  logic bitTick,
    input  logic samplePulse,
    input  logic rateSelector,
    input  logic rxBit,
    input  logic errReq,
    input  logic errorPassive,
    output logic txOut,
    output logic busy,
    output logic frameDone,
    output logic stuckDominant,
    output logic delimError
);
    localparam int CW = $clog2(max3(FLAG_BITS, DELIM_BITS, STUCK_BITS) + 1);
    localparam logic [CW-1:0] FLAG_N     = CW'(FLAG_BITS);
    localparam logic [CW-1:0] DELIM_LAST = CW'(DELIM_BITS - 1);
    localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_BITS - 1);

    state_t state;
    logic [CW-1:0] bit_cnt, dom_cnt, delim_cnt;
    logic pending, sample_valid;

    sample_qualifier u_qual (
        .clk(clk),
        .resetN(resetN),
        .samplePulse(samplePulse),
        .rateSelector(rateSelector),
        .sampleValid(sample_valid)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            dom_cnt       <= '0;
            delim_cnt     <= '0;
            pending       <= 1'b0;
            txOut         <= 1'b1;
            busy          <= 1'b0;
            frameDone     <= 1'b0;
            stuckDominant <= 1'b0;
            delimError    <= 1'b0;
        end else begin
            frameDone     <= 1'b0;
            stuckDominant <= 1'b0;
            delimError    <= 1'b0;
            case (state)
                IDLE: begin
                    txOut <= 1'b1;
                    if (errReq) begin
                        pending <= 1'b1;
                        busy    <= 1'b1;
                    end
                    // txOut itself holds the latched passive level for the whole flag
                    if (bitTick && (pending || errReq)) begin
                        state   <= FLAG;
                        bit_cnt <= CW'(1);
                        txOut   <= errorPassive;
                    end
                end
                FLAG: if (bitTick) begin
                    if (bit_cnt == FLAG_N) begin
                        state   <= WAIT_REC;
                        txOut   <= 1'b1;
                        dom_cnt <= '0;
                    end else
                        bit_cnt <= bit_cnt + 1'b1;
                end
                WAIT_REC: if (sample_valid) begin
                    if (rxBit) begin
                        state     <= DELIM;
                        delim_cnt <= CW'(1);
                    end else if (dom_cnt == STUCK_LAST) begin
                        stuckDominant <= 1'b1;
                        dom_cnt       <= '0;
                    end else
                        dom_cnt <= dom_cnt + 1'b1;
                end
                DELIM: if (sample_valid) begin
                    if (!rxBit) begin
                        delimError <= 1'b1;
                        state      <= IDLE;
                    end else if (delim_cnt == DELIM_LAST) begin
                        frameDone <= 1'b1;
                        busy      <= 1'b0;
                        pending   <= 1'b0;
                        state     <= IDLE;
                    end else
                        delim_cnt <= delim_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_err_frame_tx.sv
// tb_err_frame_tx: bit-level scenarios for err_frame_tx checked against a sequence-analysis model
module tb_err_frame_tx;
    localparam int NB = 48;
    localparam int BP = 12;

    logic clk = 0, resetN = 0, bitTick = 0, samplePulse = 0, rateSelector = 0;
    logic rxBit = 1, errReq = 0, errorPassive = 0;
    logic txOut, busy, frameDone, stuckDominant, delimError;
    int total = 0, bad = 0;

    logic rx_q[NB], pv_q[NB];
    logic tx_e[NB], busy_e[NB], done_e[NB], stuck_e[NB], derr_e[NB];

    err_frame_tx dut (
        .clk(clk), .resetN(resetN), .bitTick(bitTick), .samplePulse(samplePulse),
        .rateSelector(rateSelector), .rxBit(rxBit), .errReq(errReq), .errorPassive(errorPassive),
        .txOut(txOut), .busy(busy), .frameDone(frameDone), .stuckDominant(stuckDominant),
        .delimError(delimError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int b, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s bit=%0d observed=%b expected=%b", tag, b, obs, exp);
        end
    endtask

    task automatic fill(input logic rx, input logic pv);
        for (int i = 0; i < NB; i++) begin
            rx_q[i] = rx;
            pv_q[i] = pv;
        end
    endtask

    // Walks the per-bit bus levels: 6 flag bits, a dominant run, then 8 recessive or a restart
    task automatic build_model(input int n);
        int start, p, d, k, done_at;
        for (int i = 0; i < NB; i++) begin
            tx_e[i] = 1; done_e[i] = 0; stuck_e[i] = 0; derr_e[i] = 0;
        end
        start = 0;
        done_at = -1;
        while (start < n) begin
            for (int j = 0; j < 6; j++)
                if (start + j < n) tx_e[start + j] = pv_q[start];
            p = start + 6;
            d = 0;
            while (p < n && !rx_q[p]) begin
                d++;
                if (d % 8 == 0) stuck_e[p] = 1;
                p++;
            end
            k = 0;
            while (p < n && rx_q[p] && k < 8) begin
                k++;
                if (k == 8) begin done_e[p] = 1; done_at = p; end
                p++;
            end
            if (done_at >= 0 || p >= n) break;
            derr_e[p] = 1;
            start = p + 1;
        end
        for (int i = 0; i < NB; i++) busy_e[i] = done_at < 0 || i < done_at;
    endtask

    task automatic do_bit(input int b, input logic same_req, input logic ign_req);
        logic dn, st, de;
        dn = 0; st = 0; de = 0;
        for (int c = 0; c < BP; c++) begin
            @(negedge clk);
            if (c > 0) begin
                dn |= frameDone;
                st |= stuckDominant;
                de |= delimError;
            end
            if (c > 0 && frameDone) check("busy_at_done", b, busy, 1'b0);
            if (c == BP - 1) begin
                check("tx", b, txOut, tx_e[b]);
                check("busy", b, busy, busy_e[b]);
            end
            bitTick = c == 0;
            errReq = (c == 0 && same_req) || (c == 7 && ign_req);
            samplePulse = rateSelector ? (c == 4 || c == 6 || c == 8) : (c == 4);
            if (c == 0) begin
                rxBit = rx_q[b];
                errorPassive = pv_q[b];
            end
        end
        check("frameDone", b, dn, done_e[b]);
        check("stuckDominant", b, st, stuck_e[b]);
        check("delimError", b, de, derr_e[b]);
    endtask

    task automatic run_scn(input int n, input logic rate, input logic same, input int ig);
        @(negedge clk);
        resetN = 0;
        rateSelector = rate;
        repeat (2) @(negedge clk);
        check("rst_tx", -1, txOut, 1'b1);
        check("rst_busy", -1, busy, 1'b0);
        check("rst_pulses", -1, frameDone | stuckDominant | delimError, 1'b0);
        resetN = 1;
        build_model(n);
        if (!same) begin
            @(negedge clk);
            errReq = 1;
            @(negedge clk);
            errReq = 0;
            check("busy_req", -1, busy, 1'b1);
            check("tx_req", -1, txOut, 1'b1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        for (int b = 0; b < n; b++)
            do_bit(b, same && b == 0, b == ig && busy_e[b] && b > 0);
    endtask

    initial begin
        int n, thr;
        // active flag, recessive bus
        fill(1, 0);
        run_scn(16, 0, 0, 3);
        // passive flag
        fill(1, 1);
        run_scn(16, 0, 1, 8);
        // superposition: 5 dominant samples after the flag
        fill(1, 0);
        for (int i = 6; i < 11; i++) rx_q[i] = 0;
        run_scn(22, 0, 0, -1);
        // stuck dominant bus
        fill(1, 0);
        for (int i = 6; i < 22; i++) rx_q[i] = 0;
        run_scn(24, 0, 0, 12);
        // dominant on 4th delimiter sample, triple sampling
        fill(1, 0);
        rx_q[9] = 0;
        run_scn(26, 1, 0, -1);
        // triple sampling, clean frame
        fill(1, 0);
        run_scn(16, 1, 1, 5);
        // reset in the middle of the flag
        fill(1, 0);
        run_scn(3, 0, 0, -1);
        @(negedge clk);
        resetN = 0;
        @(negedge clk);
        check("midrst_tx", -1, txOut, 1'b1);
        check("midrst_busy", -1, busy, 1'b0);
        resetN = 1;
        // randomized bus traffic
        for (int s = 0; s < 20; s++) begin
            n = $urandom_range(20, NB);
            thr = $urandom_range(4, 10);
            for (int i = 0; i < NB; i++) begin
                rx_q[i] = $urandom_range(0, 9) < thr;
                pv_q[i] = $urandom_range(0, 3) == 0;
            end
            run_scn(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, n - 1));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
